// File: rtl/b01_pkg.sv
// Shared definitions for consumers of the b01 serial comparator/adder stage.
// Collector state encoding and the default assembled-word width.
package b01_pkg;

  localparam int B01_DESER_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } b01_coll_state_e;

endpackage

// File: rtl/b01_word_reg.sv
// Single-entry valid/ready output register with overrun detection.
// A load that arrives while full and not draining is dropped and flagged.
module b01_word_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_clr_overrun,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_overrun,
  output logic              o_loaded
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_drain;
  logic              w_accept;
  logic              w_drop;

  // A same-cycle drain frees the slot, so back-to-back words never stall.
  assign w_drain  = r_valid & i_ready;
  assign w_accept = i_load & (~r_valid | w_drain);
  assign w_drop   = i_load & r_valid & ~i_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= i_load_data;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (i_clr_overrun) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
  assign o_loaded  = w_accept;

endmodule

// File: rtl/b01_result_deser.sv
// Assembles b01 serial outp bits LSB-first into WIDTH-bit words on a valid/ready port.
// Optional word parity output enabled by defining B01_DESER_PARITY_EN.
//
// state   | meaning
// IDLE    | no partial word held; next accepted bit lands in position 0
// COLLECT | partial word in progress; r_pos is the next bit position
module b01_result_deser
  import b01_pkg::*;
#(
  parameter int WIDTH = B01_DESER_WIDTH_DEF,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             outp_in,
  input  logic             overflw_in,
  input  logic             sync,
  output logic [WIDTH-1:0] word_data,
  output logic             word_ovf,
`ifdef B01_DESER_PARITY_EN
  output logic             word_par,
`endif
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef B01_DESER_PARITY_EN
  localparam int PAY_W = WIDTH + 2;
`else
  localparam int PAY_W = WIDTH + 1;
`endif

  b01_coll_state_e   r_state;
  b01_coll_state_e   w_state_nxt;
  logic [POS_W-1:0]  r_pos;
  logic [WIDTH-1:0]  r_word;
  logic [WIDTH-1:0]  w_word_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;
  logic              w_take;
  logic              w_complete;
  logic [PAY_W-1:0]  w_payload;
  logic [PAY_W-1:0]  w_out_payload;
  logic              w_loaded;
  logic [CNT_W-1:0]  r_ovf_count;
`ifdef B01_DESER_PARITY_EN
  logic              r_par;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (sync) begin
      w_state_nxt = IDLE;
    end else if (bit_en) begin
      case (r_state)
        IDLE:    w_state_nxt = COLLECT;
        COLLECT: if (r_pos == LAST_POS) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // sync outranks bit_en: a bit arriving with sync is discarded.
  always_comb begin
    w_take     = 1'b0;
    w_complete = 1'b0;
    if (!sync && bit_en) begin
      w_take     = 1'b1;
      w_complete = (r_state == COLLECT) && (r_pos == LAST_POS);
    end
  end

  always_comb begin
    w_word_nxt = r_word;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_pos == POS_W'(i)) w_word_nxt[i] = outp_in;
    end
    w_ovf_nxt = r_ovf | overflw_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pos  <= '0;
      r_word <= '0;
      r_ovf  <= 1'b0;
    end else if (sync || w_complete) begin
      r_pos  <= '0;
      r_word <= '0;
      r_ovf  <= 1'b0;
    end else if (w_take) begin
      r_pos  <= r_pos + POS_W'(1);
      r_word <= w_word_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

`ifdef B01_DESER_PARITY_EN
  // Running parity keeps the load path to a single XOR with the last bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else if (sync || w_complete) begin
      r_par <= 1'b0;
    end else if (w_take) begin
      r_par <= r_par ^ outp_in;
    end
  end

  assign w_payload = {r_par ^ outp_in, w_ovf_nxt, w_word_nxt};
  assign word_par  = w_out_payload[WIDTH+1];
`else
  assign w_payload = {w_ovf_nxt, w_word_nxt};
`endif

  b01_word_reg #(
    .DATA_W (PAY_W)
  ) u_word_reg (
    .clock         (clock),
    .reset         (reset),
    .i_load        (w_complete),
    .i_load_data   (w_payload),
    .i_clr_overrun (sync),
    .i_ready       (word_ready),
    .o_data        (w_out_payload),
    .o_valid       (word_valid),
    .o_overrun     (overrun),
    .o_loaded      (w_loaded)
  );

  assign word_data = w_out_payload[WIDTH-1:0];
  assign word_ovf  = w_out_payload[WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf_count <= '0;
    end else if (w_loaded && w_ovf_nxt && (r_ovf_count != CNT_MAX)) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_b01_result_deser.sv
// Directed and randomized bench for b01_result_deser against a queue-based word model.
module tb_b01_result_deser;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             bit_en = 1'b0;
  logic             outp_in = 1'b0;
  logic             overflw_in = 1'b0;
  logic             sync = 1'b0;
  logic             word_ready = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic             word_ovf;
  logic             word_valid;
  logic             overrun;
  logic [CNT_W-1:0] ovf_count;
`ifdef B01_DESER_PARITY_EN
  logic             word_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: words as bit queues, one-entry output slot.
  bit               m_bits[$];
  logic             m_povf;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_wovf;
  logic             m_overrun;
  int               m_count;

  b01_result_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bit_en     (bit_en),
    .outp_in    (outp_in),
    .overflw_in (overflw_in),
    .sync       (sync),
    .word_data  (word_data),
    .word_ovf   (word_ovf),
`ifdef B01_DESER_PARITY_EN
    .word_par   (word_par),
`endif
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .ovf_count  (ovf_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_bits.delete();
    m_povf    = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_wovf    = 1'b0;
    m_overrun = 1'b0;
    m_count   = 0;
  endfunction

  function automatic void model_edge(input logic be, input logic d, input logic ov,
                                     input logic sy, input logic rd);
    logic             drain;
    logic             comp;
    logic [WIDTH-1:0] w;
    logic             wo;
    drain = m_valid && rd;
    comp  = 1'b0;
    w     = '0;
    wo    = 1'b0;
    if (sy) begin
      m_bits.delete();
      m_povf    = 1'b0;
      m_overrun = 1'b0;
    end else if (be) begin
      m_bits.push_back(d);
      m_povf = m_povf | ov;
      if (m_bits.size() == WIDTH) begin
        comp = 1'b1;
        for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
        wo = m_povf;
        m_bits.delete();
        m_povf = 1'b0;
      end
    end
    if (comp && (!m_valid || drain)) begin
      m_valid = 1'b1;
      m_data  = w;
      m_wovf  = wo;
      if (wo && m_count < CMAX) m_count++;
    end else begin
      if (comp) m_overrun = 1'b1;
      if (drain) m_valid = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
    chk({tag, ".word_data"},  32'(word_data),  32'(m_data));
    chk({tag, ".word_ovf"},   32'(word_ovf),   32'(m_wovf));
    chk({tag, ".overrun"},    32'(overrun),    32'(m_overrun));
    chk({tag, ".ovf_count"},  32'(ovf_count),  32'(m_count));
`ifdef B01_DESER_PARITY_EN
    chk({tag, ".word_par"},   32'(word_par),   32'(^m_data));
`endif
  endtask

  task automatic step(input string tag, input logic be, input logic d, input logic ov,
                      input logic sy, input logic rd);
    @(negedge clock);
    bit_en     = be;
    outp_in    = d;
    overflw_in = ov;
    sync       = sy;
    word_ready = rd;
    @(posedge clock);
    model_edge(be, d, ov, sy, rd);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [WIDTH-1:0] w,
                           input logic [WIDTH-1:0] om, input logic rd);
    for (int i = 0; i < WIDTH; i++) step(tag, 1'b1, w[i], om[i], 1'b0, rd);
  endtask

  // Asserts reset away from any clock edge and checks outputs drop at once.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, ".rst_valid"},   32'(word_valid), 32'd0);
    chk({tag, ".rst_data"},    32'(word_data),  32'd0);
    chk({tag, ".rst_ovf"},     32'(word_ovf),   32'd0);
    chk({tag, ".rst_overrun"}, 32'(overrun),    32'd0);
    chk({tag, ".rst_count"},   32'(ovf_count),  32'd0);
    model_reset();
    @(negedge clock);
    bit_en = 1'b0;
    sync   = 1'b0;
    reset  = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] rw;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;

    // Basic word 8'h4D with ready high
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH - 1; i++) begin
      rw = 8'h4D;
      step("w4d", 1'b1, rw[i], 1'b0, 1'b0, 1'b1);
    end
    chk("w4d.not_yet_valid", 32'(word_valid), 32'd0);
    step("w4d_last", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w4d.valid", 32'(word_valid), 32'd1);
    chk("w4d.data",  32'(word_data),  32'h4D);
    chk("w4d.ovf",   32'(word_ovf),   32'd0);
    chk("w4d.count", 32'(ovf_count),  32'd0);

    // Overflow on bit 5 only, then a clean word
    send_word("ovf5", 8'h4D, 8'h20, 1'b1);
    chk("ovf5.ovf",   32'(word_ovf),  32'd1);
    chk("ovf5.count", 32'(ovf_count), 32'd1);
    send_word("clean", 8'h4D, 8'h00, 1'b1);
    chk("clean.ovf",   32'(word_ovf),  32'd0);
    chk("clean.count", 32'(ovf_count), 32'd1);
    step("drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: two words with the consumer stalled
    send_word("aa", 8'hAA, 8'h00, 1'b0);
    send_word("55", 8'h55, 8'h00, 1'b0);
    chk("ovr.data",    32'(word_data), 32'hAA);
    chk("ovr.overrun", 32'(overrun),   32'd1);
    step("ovr_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr.drained", 32'(word_valid), 32'd0);

    // Sync discards a partial word and clears overrun
    for (int i = 0; i < 3; i++) step("part", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("sync", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sync.overrun", 32'(overrun), 32'd0);
    step("sync_bit", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word("w0f", 8'h0F, 8'h00, 1'b1);
    chk("w0f.data",  32'(word_data),  32'h0F);
    chk("w0f.valid", 32'(word_valid), 32'd1);

    // Saturating overflow-word counter
    async_reset("sat");
    for (int k = 0; k < 17; k++) begin
      rw = 8'(k * 37 + 5);
      send_word("sat", rw, 8'(8'h01 << (k % 8)), 1'b1);
    end
    chk("sat.count", 32'(ovf_count), 32'd15);

    // Reset mid-word and mid-hold
    async_reset("pre");
    for (int i = 0; i < 4; i++) step("mid", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    async_reset("midword");
    send_word("after", 8'h3C, 8'h00, 1'b1);
    chk("after.data",  32'(word_data), 32'h3C);
    chk("after.count", 32'(ovf_count), 32'd0);
    send_word("hold", 8'hC3, 8'h00, 1'b0);
    step("hold2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold.valid", 32'(word_valid), 32'd1);
    async_reset("midhold");
    send_word("after2", 8'h96, 8'h00, 1'b1);
    chk("after2.data", 32'(word_data), 32'h96);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      step("rand",
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/b01_result_deser.md
Name: b01_result_deser

Overview:
- Downstream consumer of the b01 serial comparator/adder stage.
- Samples b01's serial `outp` bit stream and its `overflw` flag, and assembles WIDTH bits LSB-first into parallel words.
- Presents each word on a valid/ready output port with a per-word overflow flag, a sticky overrun flag and a saturating overflow-word counter.
- Sits between the b01 core and the parallel result bus.

Parameters:
- WIDTH, 8: bits per assembled word (>=2).
- CNT_W, 4: width of the overflow-word counter.

Ports:
- clock  in  1  rising-edge clock, shared with b01.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- bit_en  in  1  current outp_in/overflw_in bit is valid; sampled on the rising edge.
- outp_in  in  1  serial data bit, driven from b01 outp.
- overflw_in  in  1  overflow flag, driven from b01 overflw.
- sync  in  1  word-alignment restart; discards the partial word.
- word_data  out  WIDTH  assembled word; bit 0 = first bit received.
- word_ovf  out  1  overflw_in was 1 on at least one accepted bit of the word.
- word_valid  out  1  output register holds a word.
- word_ready  in  1  consumer accepts the word when word_valid & word_ready.
- overrun  out  1  sticky: a completed word was dropped.
- ovf_count  out  CNT_W  number of words loaded with word_ovf=1; saturating.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, bit counter 0, partial word 0, collector in IDLE, output register EMPTY.
- Collector FSM:
  - IDLE: bit_en=1 -> capture bit into position 0, cnt=1, go to COLLECT.
  - COLLECT: each bit_en=1 stores outp_in at position cnt and increments cnt.
  - When the bit at position WIDTH-1 is accepted the word completes, cnt returns to 0 and the FSM returns to IDLE. The next bit_en in the following cycle starts a new word with no bubble.
  - bit_en=0: hold all state.
- Overflow accumulation: the partial ovf flag is the OR of overflw_in over all accepted bits of the current word; it clears when a word completes.
- Word completion when the output register is EMPTY, or draining in the same cycle (word_valid & word_ready):
  - Load word_data/word_ovf; word_valid=1 in the next cycle (latency 1 clock after the last bit's edge).
  - Throughput is one word per WIDTH accepted bits.
- Word completion when the output register is FULL and not draining:
  - Drop the new word; register contents are unchanged.
  - overrun <= 1; it stays set until reset or sync.
- Handshake:
  - word_valid, once high, holds until the cycle after word_valid & word_ready.
  - word_data and word_ovf are stable while word_valid=1.
  - With no new load, a drain sets word_valid=0 next cycle.
- ovf_count: increments by 1 on each load with word_ovf=1; holds at 2^CNT_W-1 (no wrap).
- sync=1:
  - Next edge: cnt=0, partial word and partial ovf cleared, FSM to IDLE, overrun cleared.
  - sync has priority over bit_en in the same cycle; that bit is discarded.
  - No effect on the output register, word_valid or ovf_count.
- Simultaneous completion with sync=1: sync wins, nothing is loaded.
- Reset mid-word: the partial word is lost; no output is produced for it.

Optional Feature:
- Macro: B01_DESER_PARITY_EN.
- Defined:
  - Adds output word_par (1 bit) = XOR of the WIDTH bits of word_data.
  - Registered alongside word_data on load; reset 0.
  - Parity is computed incrementally during collection, with no combinational WIDTH-input XOR at load.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package b01_pkg:
  - collector state typedef (IDLE, COLLECT);
  - constant B01_DESER_WIDTH_DEF = 8.
- One sub-module b01_word_reg: single-entry valid/ready output register (load, drain, full, overrun-detect), reusable by other b01 consumers.
- Collector FSM, shift/position logic and counter stay in the top.

Test Plan:
- Reset then 8 bits with bit_en=1 and outp_in=1,0,1,1,0,0,1,0 (first to last), overflw_in=0, word_ready=1 -> word_data=8'h4D and word_ovf=0, valid exactly one cycle after the 8th bit; ovf_count=0.
- Same stream with overflw_in=1 only on bit 5 -> word_ovf=1, ovf_count=1; next word with overflw_in=0 -> word_ovf=0, ovf_count stays 1.
- word_ready=0, two consecutive 8-bit words 8'hAA then 8'h55 -> word_data holds 8'hAA, overrun=1 one cycle after the 2nd word completes; assert word_ready -> 8'hAA drains, word_valid=0.
- 3 bits, sync=1 for one cycle, then 8 bits forming 8'h0F -> output 8'h0F (earlier bits discarded), overrun cleared; sync together with bit_en -> that bit ignored.
- With CNT_W=4, 17 words each containing one overflw_in=1 bit -> ovf_count reaches 15 and holds.
- reset=0 asynchronously mid-word (after bit 4) and mid-hold (word_valid=1) -> all outputs 0 immediately; next 8 bits after release form a clean word.
